// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronizes the bus into clk, shifts in one
// FRAME_BITS word per chip-select window and streams tx_data back on spi_miso.
module spi_slave_rx #(
    parameter int FRAME_BITS  = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sclk,
    input  logic                  spi_data,
    input  logic                  spi_cs,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  spi_miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_error,
    output logic                  rx_overrun,
    output logic                  busy,
    output logic [7:0]            counter,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAME_BITS - 1);
    localparam logic [7:0] FULL_CNT = 8'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;

    logic sclk_s;
    logic data_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;

    // The final bit goes straight into rx_data, so the receive shifter only
    // ever needs to hold the first FRAME_BITS-1 bits.
    state_t                state, state_n;
    logic [FRAME_BITS-2:0] rx_shift, rx_shift_n;
    logic [FRAME_BITS-1:0] tx_shift, tx_shift_n;
    logic [FRAME_BITS-1:0] rx_data_n;
    logic [7:0]            counter_n;
    logic                  rx_valid_n;
    logic                  rx_error_n;
    logic                  rx_overrun_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync <= '0;
            data_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // rx_valid, rx_error and rx_overrun are single-clk strobes with no ready:
    // the consumer must take rx_data in the cycle rx_valid is high.
    always_comb begin
        state_n      = state;
        rx_shift_n   = rx_shift;
        tx_shift_n   = tx_shift;
        rx_data_n    = rx_data;
        counter_n    = counter;
        rx_valid_n   = 1'b0;
        rx_error_n   = 1'b0;
        rx_overrun_n = 1'b0;

        unique case (state)
            IDLE: begin
                counter_n  = '0;
                tx_shift_n = '0;
                if (!cs_s) begin
                    state_n    = SHIFT;
                    rx_shift_n = '0;
                    tx_shift_n = tx_data;
                end
            end

            SHIFT: begin
                if (sclk_rise && counter == LAST_CNT) begin
                    // A completing edge wins over a simultaneous deselect.
                    rx_data_n  = {rx_shift, data_s};
                    rx_valid_n = 1'b1;
                    if (cs_s) begin
                        state_n    = IDLE;
                        counter_n  = '0;
                        tx_shift_n = '0;
                    end else begin
                        state_n   = WAIT_CS;
                        counter_n = FULL_CNT;
                    end
                end else if (cs_s) begin
                    state_n    = IDLE;
                    counter_n  = '0;
                    tx_shift_n = '0;
                    rx_error_n = (counter != 8'd0);
                end else if (sclk_rise) begin
                    rx_shift_n = {rx_shift[FRAME_BITS-3:0], data_s};
                    counter_n  = counter + 8'd1;
                end else if (sclk_fall) begin
                    tx_shift_n = {tx_shift[FRAME_BITS-2:0], 1'b0};
                end
            end

            WAIT_CS: begin
                if (cs_s) begin
                    state_n    = IDLE;
                    counter_n  = '0;
                    tx_shift_n = '0;
                end else if (sclk_rise) begin
                    rx_overrun_n = 1'b1;
                end else if (sclk_fall) begin
                    tx_shift_n = {tx_shift[FRAME_BITS-2:0], 1'b0};
                end
            end

            default: begin
                state_n    = IDLE;
                counter_n  = '0;
                tx_shift_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rx_shift   <= '0;
            tx_shift   <= '0;
            rx_data    <= '0;
            counter    <= '0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_n;
            rx_shift   <= rx_shift_n;
            tx_shift   <= tx_shift_n;
            rx_data    <= rx_data_n;
            counter    <= counter_n;
            rx_valid   <= rx_valid_n;
            rx_error   <= rx_error_n;
            rx_overrun <= rx_overrun_n;
        end
    end

    // tx_shift is cleared whenever the FSM sits in IDLE, so its MSB is the bus bit.
    assign spi_miso  = tx_shift[FRAME_BITS-1];
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule
